// File: rtl/cfg_chain_pkg.sv
// cfg_chain_pkg
// Shared types and constants for the configuration scan-chain bank:
//   - session_state_t : shift-session state (IDLE, SHIFT, FULL, OVER)
//   - cnt_width()     : width of a counter able to hold 0..width
//   - CFG_DEFAULT_WIDTH / CFG_RST_BIT : default chain length and reset bit
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        OVER  = 2'd3
    } session_state_t;

    localparam int unsigned CFG_DEFAULT_WIDTH = 8;

    // Every chain bit resets to this value unless RESET_VAL overrides it.
    localparam logic CFG_RST_BIT = 1'b0;

    // Bits needed to count shifts from 0 up to and including width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cfg_chain_session_fsm.sv
// cfg_chain_session_fsm
// Tracks one shift session of the configuration chain: detects the rising
// edge of SE, counts shift edges and flags an exact or excessive shift count.
// Ports:
//   CK        in   clock, rising edge
//   RSTN      in   asynchronous active-low reset
//   SE        in   scan/shift enable
//   LOADED    out  exactly WIDTH shifts seen in the current session
//   OVERSHIFT out  more than WIDTH shifts seen in the current session (sticky)
module cfg_chain_session_fsm
    import cfg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = CFG_DEFAULT_WIDTH
) (
    input  logic CK,
    input  logic RSTN,
    input  logic SE,
    output logic LOADED,
    output logic OVERSHIFT
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    session_state_t   state;
    session_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             se_q;
    logic             start;

    assign start   = SE & ~se_q;
    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            se_q  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            se_q  <= SE;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (start) begin
            // First shift edge of a new session; WIDTH >= 2 so never FULL here.
            cnt_nxt   = CNT_ONE;
            state_nxt = SHIFT;
        end else if (SE) begin
            case (state)
                SHIFT: begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    state_nxt = OVER;
                    cnt_nxt   = CNT_MAX;
                end
                OVER: begin
                    cnt_nxt = CNT_MAX;
                end
                default: begin
                    // IDLE with SE already high: no session in progress.
                end
            endcase
        end else if (state == SHIFT) begin
            // Partial session ends; count is kept but never reports LOADED.
            state_nxt = IDLE;
        end
    end

    assign LOADED    = (state == FULL);
    assign OVERSHIFT = (state == OVER);

endmodule

// File: rtl/cfg_scan_chain_bank.sv
// cfg_scan_chain_bank
// Bank of WIDTH scan-capable configuration flops. Data shifts in on SI
// (entering bit 0) or is captured in parallel from D; the contents are
// released to the fabric only once a complete shift session has been seen
// and CFGE is high.
// Ports:
//   CK        in   clock, rising edge
//   RSTN      in   asynchronous active-low reset
//   SE        in   shift enable (has priority over LOAD)
//   SI        in   scan input
//   SO        out  scan output, Q[WIDTH-1]
//   LOAD      in   parallel capture enable
//   D         in   parallel data
//   CFGE      in   configure enable
//   Q         out  raw register contents
//   CFGQ      out  released data (zero when not released)
//   CFGQN     out  released inverted data (all ones when not released)
//   LOADED    out  exactly WIDTH shifts completed in the current session
//   OVERSHIFT out  sticky: more than WIDTH shifts in the current session
module cfg_scan_chain_bank
    import cfg_chain_pkg::*;
#(
    parameter int unsigned      WIDTH     = CFG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CFG_RST_BIT}}
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CFGE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] CFGQ,
    output logic [WIDTH-1:0] CFGQN,
    output logic             LOADED,
    output logic             OVERSHIFT
);

    if (WIDTH < 2) begin : g_width_check
        $error("cfg_scan_chain_bank: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] chain;
    logic             rel;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            chain <= RESET_VAL;
        end else if (SE) begin
            chain <= {chain[WIDTH-2:0], SI};
        end else if (LOAD) begin
            chain <= D;
        end
    end

    cfg_chain_session_fsm #(
        .WIDTH (WIDTH)
    ) u_session (
        .CK        (CK),
        .RSTN      (RSTN),
        .SE        (SE),
        .LOADED    (LOADED),
        .OVERSHIFT (OVERSHIFT)
    );

    // CFGE is deliberately unregistered; LOADED comes from the state register.
    assign rel   = CFGE & LOADED;
    assign Q     = chain;
    assign SO    = chain[WIDTH-1];
    assign CFGQ  = rel ? chain  : '0;
    assign CFGQN = rel ? ~chain : '1;

endmodule

// File: doc/cfg_scan_chain_bank.md
Name: cfg_scan_chain_bank

Overview:
- Parametrised bank of WIDTH scan-capable configuration flip-flops with async active-low reset and per-bit reset value.
- Generalises the single-bit configurable scan flop to a chain with bit-count tracking, a "loaded" status and overshift detection.
- Configuration outputs are released only when configure-enable is high and a complete shift session has been observed.
- Sits between the configuration protocol controller and the fabric's LUT/mux configuration bits.

Parameters:
- WIDTH, 8, number of flops in the chain; must be >= 2, elaboration error otherwise.
- RESET_VAL, {WIDTH{1'b0}}, per-bit async reset value; bit i loads RESET_VAL[i].
- CNT_W, derived localparam clog2(WIDTH+1), shift-counter width; not overridable.

Ports:
- CK  input  1  clock, rising-edge.
- RSTN  input  1  reset.
- SE  input  1  scan/shift enable.
- SI  input  1  scan input, enters bit 0.
- SO  output  1  scan output = Q[WIDTH-1].
- LOAD  input  1  parallel capture enable.
- D  input  WIDTH  parallel data.
- CFGE  input  1  configure enable.
- Q  output  WIDTH  raw register contents.
- CFGQ  output  WIDTH  released data.
- CFGQN  output  WIDTH  released inverted data.
- LOADED  output  1  exactly WIDTH shifts completed in the current session.
- OVERSHIFT  output  1  sticky: more than WIDTH shifts in the current session.

Behaviour:
- Clock/reset (already decided): one clock CK; reset RSTN is asynchronous and active-low.
- RSTN low, immediately:
  - Q = RESET_VAL; SO = RESET_VAL[WIDTH-1].
  - Shift counter = 0; session FSM = IDLE; se_q = 0.
  - LOADED = 0; OVERSHIFT = 0; CFGQ = 0; CFGQN = all ones.
- Reset deassertion takes effect at the first CK edge with RSTN high.
- Reset mid-session aborts the session; there is no partial-state retention.
- Per-edge priority on Q: SE > LOAD > hold.
- SE = 1:
  - Q <= {Q[WIDTH-2:0], SI}.
  - D and LOAD are ignored.
- SE = 0, LOAD = 1:
  - Q <= D.
  - Session FSM and counter are unchanged, so LOADED is unaffected.
- Session FSM, registered, with state signals IDLE / SHIFT / FULL / OVER:
  - Session start: SE = 1 while se_q = 0 (se_q is SE delayed one cycle). The counter is set to 1; state = SHIFT if WIDTH > 1.
  - SHIFT, SE = 1: counter increments. When it reaches WIDTH, state = FULL.
  - FULL, SE = 1: state = OVER; counter saturates at WIDTH.
  - OVER: held until the next session start or reset.
  - SE = 0 in SHIFT (partial session): state returns to IDLE, counter holds its value, LOADED stays 0.
  - SE = 0 in FULL or OVER: state is held.
  - A new session start from any state restarts counting and clears OVER.
- Status outputs (registered, decoded from state):
  - LOADED = (state == FULL).
  - OVERSHIFT = (state == OVER).
  - Both are visible in the cycle after the WIDTH-th (resp. WIDTH+1-th) shift edge.
- Release logic (combinational from registered state; CFGE is not registered):
  - rel = CFGE & LOADED.
  - CFGQ = rel ? Q : 0.
  - CFGQN = rel ? ~Q : all ones.
- LOAD after FULL keeps LOADED = 1, so CFGQ reflects the newly captured D. This is intentional and is used for readback/overwrite.
- No combinational path from SI to SO.

Decomposition:
- Package cfg_chain_pkg:
  - Session-state enum (IDLE, SHIFT, FULL, OVER).
  - clog2-based counter-width function.
  - Default-reset-value constant.
- Sub-module cfg_chain_session_fsm: edge detect, counter and state. Parameter WIDTH; inputs CK, RSTN, SE; outputs LOADED, OVERSHIFT.
- Top level holds the shift register and the release logic.

Test Plan:
1. Reset and release with no session:
   - Stimulus: WIDTH = 8, RESET_VAL = 8'hA5, assert RSTN = 0 mid-cycle.
   - Required: Q = 8'hA5 immediately, SO = 1, CFGQ = 0, CFGQN = 8'hFF, LOADED = 0. Raising CFGE = 1 without a session keeps CFGQ = 0.
2. Exact shift session:
   - Stimulus: shift SI sequence 1,0,1,1,0,0,1,0 over 8 consecutive SE cycles, then SE = 0, CFGE = 1.
   - Required: Q = 8'hB2, LOADED = 1 from the cycle after the 8th edge, CFGQ = 8'hB2, CFGQN = 8'h4D.
3. Overshift:
   - Stimulus: 9 consecutive SE cycles.
   - Required: LOADED pulses for one cycle, then OVERSHIFT = 1 and LOADED = 0, CFGQ = 0 with CFGE = 1. A new session of 8 clears OVERSHIFT and sets LOADED.
4. Partial session and restart:
   - Stimulus: 5 shifts, SE low for 2 cycles, then 8 shifts.
   - Required: LOADED = 0 after the first burst, LOADED = 1 only after the full 8 of the second burst.
5. Priority:
   - Stimulus: SE = 1 and LOAD = 1 with D = 8'hFF, SI = 0, Q = 8'h01.
   - Required: Q = 8'h02. Then SE = 0, LOAD = 1 gives Q = 8'hFF with LOADED unchanged.
6. Async reset mid-session:
   - Stimulus: RSTN low after the 4th shift.
   - Required: all outputs return to reset values within the same cycle; after release, the next 8 shifts produce LOADED = 1.
